// File: rtl/ex_stage_mul_pkg.sv
// Shared encodings for the execute stage: ALU op classes, R-type funct codes,
// forwarding selects and the multiply sequencing states.
package ex_stage_mul_pkg;

  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;
  localparam logic [1:0] AluOpOr    = 2'b11;

  localparam logic [5:0] FunctAdd = 6'b100000;
  localparam logic [5:0] FunctSub = 6'b100010;
  localparam logic [5:0] FunctAnd = 6'b100100;
  localparam logic [5:0] FunctOr  = 6'b100101;
  localparam logic [5:0] FunctMul = 6'b011000;

  localparam logic [1:0] FwdIdEx  = 2'b00;
  localparam logic [1:0] FwdMemWb = 2'b01;
  localparam logic [1:0] FwdExMem = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } mul_state_e;

endpackage

// File: rtl/ex_stage_mul_mul_iter.sv
// Iterative shift-add multiplier datapath: retires STEP multiplier bits per cycle
// and produces the low WIDTH bits of the product. Sequencing is owned by the caller.
module mul_iter #(
  parameter int unsigned STEP  = 1,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int unsigned ITER = WIDTH / STEP;
  localparam int unsigned CntW = $clog2(ITER);

  logic [WIDTH-1:0] a_q, b_q, acc_q, partial;
  logic [CntW-1:0]  cnt_q;
  logic             busy_q;

  always_comb begin
    partial = '0;
    for (int i = 0; i < STEP; i++) begin
      if (b_q[i]) partial = partial + (a_q << i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      a_q    <= a;
      b_q    <= b;
      acc_q  <= '0;
      cnt_q  <= CntW'(ITER - 1);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      acc_q <= acc_q + partial;
      a_q   <= a_q << STEP;
      b_q   <= b_q >> STEP;
      if (cnt_q == '0) busy_q <= 1'b0;
      else             cnt_q  <= cnt_q - 1'b1;
    end
  end

  assign busy    = busy_q;
  assign done    = busy_q && (cnt_q == '0);
  assign product = acc_q;

endmodule

// File: rtl/ex_stage_mul.sv
// Execute stage with EX/MEM register. Single-cycle ALU ops, plus an iterative MUL
// that stalls the upstream pipeline and inserts bubbles until the product is ready.
module ex_stage_mul
  import ex_stage_mul_pkg::*;
#(
  parameter int unsigned STEP  = 1,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic [WIDTH-1:0] sign_extended_i,
  input  logic [31:0]      instruction_i,
  input  logic             RegDst_i,
  input  logic             ALUSrc_i,
  input  logic             MemToReg_i,
  input  logic             RegWrite_i,
  input  logic             MemWrite_i,
  input  logic             MemRead_i,
  input  logic [1:0]       ALUOp_i,
  input  logic [1:0]       fwd_a_i,
  input  logic [1:0]       fwd_b_i,
  input  logic [WIDTH-1:0] exmem_fwd_i,
  input  logic [WIDTH-1:0] memwb_fwd_i,
  output logic             stall_o,
  output logic [WIDTH-1:0] alu_result_o,
  output logic [WIDTH-1:0] mem_wdata_o,
  output logic [4:0]       wreg_o,
  output logic             RegWrite_o,
  output logic             MemToReg_o,
  output logic             MemWrite_o,
  output logic             MemRead_o
);

  logic [WIDTH-1:0] op_a, b_fwd, op_b, alu_res, product, ex_result;
  logic [5:0]       funct;
  logic [4:0]       wreg_d;
  logic             is_mul, mul_start, mul_busy, mul_done, capture;
  logic             unused_instr;
  mul_state_e       state_q, state_d;

  assign funct        = instruction_i[5:0];
  assign wreg_d       = RegDst_i ? instruction_i[15:11] : instruction_i[20:16];
  assign is_mul       = (ALUOp_i == AluOpFunct) && (funct == FunctMul);
  assign unused_instr = ^{instruction_i[31:21], instruction_i[10:6]};

  function automatic logic [WIDTH-1:0] fwd_mux(logic [1:0] sel, logic [WIDTH-1:0] idex,
                                               logic [WIDTH-1:0] exmem,
                                               logic [WIDTH-1:0] memwb);
    case (sel)
      FwdExMem: return exmem;
      FwdMemWb: return memwb;
      default:  return idex;
    endcase
  endfunction

  assign op_a  = fwd_mux(fwd_a_i, data1_i, exmem_fwd_i, memwb_fwd_i);
  assign b_fwd = fwd_mux(fwd_b_i, data2_i, exmem_fwd_i, memwb_fwd_i);
  assign op_b  = ALUSrc_i ? sign_extended_i : b_fwd;

  always_comb begin
    alu_res = op_a + op_b;
    case (ALUOp_i)
      AluOpSub: alu_res = op_a - op_b;
      AluOpOr:  alu_res = op_a | op_b;
      AluOpFunct: begin
        case (funct)
          FunctSub: alu_res = op_a - op_b;
          FunctAnd: alu_res = op_a & op_b;
          FunctOr:  alu_res = op_a | op_b;
          default:  alu_res = op_a + op_b;
        endcase
      end
      default: ;
    endcase
  end

  mul_iter #(
    .STEP  (STEP),
    .WIDTH (WIDTH)
  ) u_mul_iter (
    .clk     (clk_i),
    .rst     (rst_i),
    .start   (mul_start),
    .a       (op_a),
    .b       (b_fwd),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (product)
  );

  // DONE always returns to IDLE so the still-held MUL in ID/EX is not re-issued.
  always_comb begin
    state_d   = state_q;
    stall_o   = 1'b0;
    mul_start = 1'b0;
    capture   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (is_mul) begin
          stall_o   = 1'b1;
          mul_start = 1'b1;
          state_d   = StBusy;
        end else begin
          capture = 1'b1;
        end
      end
      StBusy: begin
        stall_o = 1'b1;
        if (mul_done || !mul_busy) state_d = StDone;
      end
      StDone: begin
        capture = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign ex_result = (state_q == StDone) ? product : alu_res;

  // Bubbles clear only the controls; data and wreg keep their last values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      alu_result_o <= '0;
      mem_wdata_o  <= '0;
      wreg_o       <= '0;
      RegWrite_o   <= 1'b0;
      MemToReg_o   <= 1'b0;
      MemWrite_o   <= 1'b0;
      MemRead_o    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        alu_result_o <= ex_result;
        mem_wdata_o  <= b_fwd;
        wreg_o       <= wreg_d;
        RegWrite_o   <= RegWrite_i;
        MemToReg_o   <= MemToReg_i;
        MemWrite_o   <= MemWrite_i;
        MemRead_o    <= MemRead_i;
      end else begin
        RegWrite_o <= 1'b0;
        MemToReg_o <= 1'b0;
        MemWrite_o <= 1'b0;
        MemRead_o  <= 1'b0;
      end
    end
  end

endmodule
